// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule state encoding, round constants and the S-box,
// used by the key schedule and the round datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  localparam int NR_128 = 10;

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for round i (1..10); anything else yields zero.
  function automatic logic [7:0] rcon_of(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    if (i >= 4'd1 && i <= 4'd10) r = RCON[i - 4'd1];
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step_128.sv
// Single AES-128 key-schedule step, forward (dir=1) or inverse (dir=0).
// Both directions share one 4-byte SubWord.
module aes_key_step_128
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  input  logic         dir,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_in, rot, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;

  // Inverse direction needs the previous w3, which is w7 ^ w6 of the current key.
  assign sub_in = dir ? w3 : (w3 ^ w2);
  assign rot    = {sub_in[23:0], sub_in[31:24]};
  assign t      = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

  always_comb begin
    n0 = '0;
    n1 = '0;
    n2 = '0;
    n3 = '0;
    if (dir) begin
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end else begin
      n0 = w0 ^ t;
      n1 = w0 ^ w1;
      n2 = w1 ^ w2;
      n3 = w2 ^ w3;
    end
  end

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_128.sv
// On-the-fly AES-128 round-key generator (forward for encrypt, pre-expand then reverse for decrypt).
// Define AES_KSCHED_REWIND_EN to keep a start key so a finished sequence restarts in one cycle.
module aes_key_sched_128
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             enc_dec,
  input  logic             step,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             key_ready,
  output logic             busy,
  output logic             last_key
);

  if (NR != NR_128 || KEY_W != 128) begin : g_param_check
    $error("aes_key_sched_128: only NR=10 and KEY_W=128 are supported");
  end

  localparam logic [3:0] LAST_IDX = 4'(NR_128);

  ks_state_e    state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         enc_q, enc_d;
  logic         key_ready_q, key_ready_d;
  logic         busy_q, busy_d;
`ifdef AES_KSCHED_REWIND_EN
  logic [127:0] start_key_q, start_key_d;
`endif

  logic         step_fwd;
  logic [7:0]   step_rcon;
  logic [127:0] step_key;

  // Pre-expansion always runs forward; in READY the direction follows the latched mode.
  assign step_fwd  = (state_q == EXPAND) || enc_q;
  assign step_rcon = rcon_of(step_fwd ? round_idx_q + 4'd1 : round_idx_q);

  aes_key_step_128 u_step (
    .key      (round_key_q),
    .rcon     (step_rcon),
    .dir      (step_fwd),
    .next_key (step_key)
  );

  assign last_key = key_ready_q && (enc_q ? (round_idx_q == LAST_IDX) : (round_idx_q == 4'd0));

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    enc_d       = enc_q;
    key_ready_d = key_ready_q;
    busy_d      = busy_q;
`ifdef AES_KSCHED_REWIND_EN
    start_key_d = start_key_q;
`endif
    if (key_load) begin
      round_key_d = key_in;
      round_idx_d = 4'd0;
      enc_d       = enc_dec;
      if (enc_dec) begin
        state_d     = READY;
        key_ready_d = 1'b1;
        busy_d      = 1'b0;
`ifdef AES_KSCHED_REWIND_EN
        start_key_d = key_in;
`endif
      end else begin
        state_d     = EXPAND;
        key_ready_d = 1'b0;
        busy_d      = 1'b1;
      end
    end else begin
      case (state_q)
        EXPAND: begin
          round_key_d = step_key;
          round_idx_d = round_idx_q + 4'd1;
          if (round_idx_q == LAST_IDX - 4'd1) begin
            state_d     = READY;
            key_ready_d = 1'b1;
            busy_d      = 1'b0;
`ifdef AES_KSCHED_REWIND_EN
            start_key_d = step_key;
`endif
          end
        end
        READY: begin
          if (step) begin
            if (last_key) begin
`ifdef AES_KSCHED_REWIND_EN
              round_key_d = start_key_q;
              round_idx_d = enc_q ? 4'd0 : LAST_IDX;
`else
              state_d     = IDLE;
              key_ready_d = 1'b0;
`endif
            end else begin
              round_key_d = step_key;
              round_idx_d = enc_q ? round_idx_q + 4'd1 : round_idx_q - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= '0;
      enc_q       <= 1'b0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_KSCHED_REWIND_EN
      start_key_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      enc_q       <= enc_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
`ifdef AES_KSCHED_REWIND_EN
      start_key_q <= start_key_d;
`endif
    end
  end

  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign key_ready = key_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_key_sched_128.sv
// Testbench for aes_key_sched_128: FIPS-197 key vectors driven from a table and
// hand-written sequences, with expected outputs queued per cycle and checked a cycle later.
module tb_aes_key_sched_128;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_load;
  logic [127:0] key_in;
  logic         enc_dec;
  logic         step;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_ready;
  logic         busy;
  logic         last_key;

  aes_key_sched_128 dut (
    .clk       (clk),
    .reset     (reset),
    .key_load  (key_load),
    .key_in    (key_in),
    .enc_dec   (enc_dec),
    .step      (step),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_ready (key_ready),
    .busy      (busy),
    .last_key  (last_key)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         chk_ki;
    logic [127:0] key;
    logic [3:0]   idx;
    logic         ready;
    logic         busy;
    logic         last;
  } exp_t;

  typedef struct {
    logic         rst;
    logic         load;
    logic         enc;
    logic         stp;
    logic [127:0] kin;
    exp_t         exp;
    string        name;
  } vec_t;

  localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [127:0] ek [0:10];
  exp_t sb_q[$];
  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic rst, input logic load, input logic enc, input logic stp,
                              input logic [127:0] kin, input logic chk, input logic [127:0] k,
                              input logic [3:0] idx, input logic rdy, input logic bsy,
                              input logic lst, input string name);
    vec_t v;
    v.rst = rst;
    v.load = load;
    v.enc = enc;
    v.stp = stp;
    v.kin = kin;
    v.exp = '{chk_ki: chk, key: k, idx: idx, ready: rdy, busy: bsy, last: lst};
    v.name = name;
    return v;
  endfunction

  task automatic check_output(input string name);
    exp_t e;
    logic ok;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: scoreboard empty, got key=%h idx=%0d", name, round_key, round_idx);
    end else begin
      e = sb_q.pop_front();
      total++;
      ok = (key_ready === e.ready) && (busy === e.busy) && (last_key === e.last);
      if (e.chk_ki) ok = ok && (round_key === e.key) && (round_idx === e.idx);
      if (!ok) begin
        bad++;
        $display("[TB] FAIL %s: got key=%h idx=%0d rdy=%b busy=%b last=%b, want key=%h idx=%0d rdy=%b busy=%b last=%b (key/idx checked=%b)",
                 name, round_key, round_idx, key_ready, busy, last_key,
                 e.key, e.idx, e.ready, e.busy, e.last, e.chk_ki);
      end
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset    = v.rst;
    key_load = v.load;
    enc_dec  = v.enc;
    step     = v.stp;
    key_in   = v.kin;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    key_load = 1'b0;
    step     = 1'b0;
    key_in   = '0;
    check_output(v.name);
  endtask

  initial begin
    ek[0]  = KEY_A;
    ek[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ek[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ek[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ek[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ek[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ek[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ek[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ek[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ek[9]  = 128'hac7766f319fadc2128d12941575c006e;
    ek[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset = 1'b1;
    key_load = 1'b0;
    enc_dec = 1'b0;
    step = 1'b0;
    key_in = '0;

    // Reset state, then the encrypt walk and its end-of-sequence step.
    tbl.push_back(mk(1, 0, 0, 0, '0, 1, '0, 0, 0, 0, 0, "reset0"));
    tbl.push_back(mk(1, 0, 0, 0, '0, 1, '0, 0, 0, 0, 0, "reset1"));
    tbl.push_back(mk(0, 1, 1, 0, KEY_A, 1, ek[0], 0, 1, 0, 0, "enc_load"));
    for (int i = 1; i <= 10; i++)
      tbl.push_back(mk(0, 0, 0, 1, '0, 1, ek[i], 4'(i), 1, 0, i == 10, $sformatf("enc_step%0d", i)));
`ifdef AES_KSCHED_REWIND_EN
    tbl.push_back(mk(0, 0, 0, 1, '0, 1, ek[0], 0, 1, 0, 0, "enc_rewind"));
`else
    tbl.push_back(mk(0, 0, 0, 1, '0, 0, '0, 0, 0, 0, 0, "enc_end"));
    tbl.push_back(mk(0, 0, 0, 1, '0, 0, '0, 0, 0, 0, 0, "idle_step"));
`endif
    for (int i = 0; i < tbl.size(); i++) apply_stimulus(tbl[i]);

    // Decrypt: ten busy cycles, k10 at load+11, then walk back to k0.
    apply_stimulus(mk(0, 1, 0, 0, KEY_A, 0, '0, 0, 0, 1, 0, "dec_load"));
    for (int i = 1; i <= 9; i++)
      apply_stimulus(mk(0, 0, 0, 0, '0, 0, '0, 0, 0, 1, 0, $sformatf("dec_busy%0d", i)));
    apply_stimulus(mk(0, 0, 0, 0, '0, 1, ek[10], 10, 1, 0, 0, "dec_ready"));
    for (int i = 1; i <= 10; i++)
      apply_stimulus(mk(0, 0, 0, 1, '0, 1, ek[10-i], 4'(10 - i), 1, 0, i == 10, $sformatf("dec_step%0d", i)));
`ifdef AES_KSCHED_REWIND_EN
    apply_stimulus(mk(0, 0, 0, 1, '0, 1, ek[10], 10, 1, 0, 0, "dec_rewind"));
`else
    apply_stimulus(mk(0, 0, 0, 1, '0, 0, '0, 0, 0, 0, 0, "dec_end"));
`endif

    // Abort: reload with a new key five cycles into pre-expansion.
    apply_stimulus(mk(0, 1, 0, 0, KEY_A, 0, '0, 0, 0, 1, 0, "abort_load1"));
    for (int i = 1; i <= 4; i++)
      apply_stimulus(mk(0, 0, 0, 0, '0, 0, '0, 0, 0, 1, 0, $sformatf("abort_busy%0d", i)));
    apply_stimulus(mk(0, 1, 0, 0, KEY_B, 0, '0, 0, 0, 1, 0, "abort_load2"));
    for (int i = 1; i <= 9; i++)
      apply_stimulus(mk(0, 0, 0, 0, '0, 0, '0, 0, 0, 1, 0, $sformatf("abort_busy2_%0d", i)));
    apply_stimulus(mk(0, 0, 0, 0, '0, 1, KEY_B_10, 10, 1, 0, 0, "abort_k10"));

    // Collisions: steps while busy are ignored; key_load beats a simultaneous step.
    apply_stimulus(mk(0, 1, 0, 0, KEY_A, 0, '0, 0, 0, 1, 0, "coll_load"));
    for (int i = 1; i <= 9; i++)
      apply_stimulus(mk(0, 0, 0, 1, '0, 0, '0, 0, 0, 1, 0, $sformatf("coll_busy_step%0d", i)));
    apply_stimulus(mk(0, 0, 0, 0, '0, 1, ek[10], 10, 1, 0, 0, "coll_k10"));
    apply_stimulus(mk(0, 1, 1, 1, KEY_A, 1, ek[0], 0, 1, 0, 0, "coll_load_step"));

    // Reset in READY at index 4, then a step that must be ignored.
    for (int i = 1; i <= 4; i++)
      apply_stimulus(mk(0, 0, 0, 1, '0, 1, ek[i], 4'(i), 1, 0, 0, $sformatf("rst_walk%0d", i)));
    apply_stimulus(mk(1, 0, 0, 0, '0, 1, '0, 0, 0, 0, 0, "rst_mid"));
    apply_stimulus(mk(0, 0, 0, 1, '0, 1, '0, 0, 0, 0, 0, "rst_step_ignored"));

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_128.md
Name: aes_key_sched_128

Overview:
On-the-fly AES-128 round-key generator. It sits beside the 128-bit round controller and feeds the round datapath one round key per round.
- Encryption: keys are produced in forward order k0..k10.
- Decryption: the block first pre-expands to k10, then walks back to k0 with the inverse schedule.
- The controller advances the block with a one-cycle step pulse per round.

Parameters:
NR, 10, number of AES rounds; only 10 is legal (elaboration error otherwise)
KEY_W, 128, key/round-key width; only 128 is legal

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
key_load  input  1  pulse; latch key_in and enc_dec, start a new schedule
key_in  input  128  cipher key (FIPS-197 byte order, byte 0 in [127:120])
enc_dec  input  1  1 = encrypt (forward order), 0 = decrypt (reverse order); sampled only on key_load
step  input  1  pulse; advance to the next round key
round_key  output  128  current round key
round_idx  output  4  index of round_key (0..10)
key_ready  output  1  round_key/round_idx valid
busy  output  1  pre-expansion in progress
last_key  output  1  round_key is the final key of the sequence (k10 for enc, k0 for dec)

Behaviour:
- Reset values: all outputs 0; state IDLE; internal key registers 0.
- States: IDLE, EXPAND, READY.
- IDLE:
  - key_load with enc_dec=1: latch k0 = key_in, go to READY. Next cycle shows key_ready=1, round_idx=0, round_key=k0 (latency 1).
  - key_load with enc_dec=0: latch k0, go to EXPAND with the internal counter at 0.
- EXPAND:
  - One forward step per cycle; counter counts 1..10.
  - busy=1 and key_ready=0 throughout.
  - After the 10th step, go to READY with round_key=k10, round_idx=10.
  - key_ready rises exactly 11 cycles after the key_load cycle.
- READY:
  - step=1, enc: round_key <= fwd(round_key, rcon[round_idx+1]); round_idx++.
  - step=1, dec: round_key <= inv(round_key, rcon[round_idx]); round_idx--.
  - The new key is visible the cycle after step.
- Key step functions:
  - fwd: w4 = w0 ^ SubWord(RotWord(w3)) ^ rcon; w5 = w1 ^ w4; w6 = w2 ^ w5; w7 = w3 ^ w6.
  - inv: recovers w0..w3 from w4..w7 using the same S-box.
- Rcon: rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36, placed in the MSB byte of the word.
- last_key: combinational; enc: round_idx==10, dec: round_idx==0; qualified by key_ready.
- step while last_key=1: end of sequence (see Optional Feature).
- step while not READY: ignored.
- key_load in any state, including EXPAND/READY: aborts the current schedule and restarts from the new key. If key_load and step occur in the same cycle, key_load wins.
- Reset asserted mid-EXPAND or mid-READY: return to IDLE next edge; all outputs 0.
- round_idx never leaves 0..10; there is no wrap.

Optional Feature:
Macro AES_KSCHED_REWIND_EN.
- Defined:
  - The block retains a start-key register (k0 for enc, k10 for dec).
  - step at last_key reloads the start key and start index in 1 cycle; it stays READY, key_ready stays 1.
  - Repeated blocks with the same key therefore skip the 10-cycle pre-expansion.
- Undefined:
  - step at last_key goes to IDLE; key_ready=0 next cycle.
  - The key must be reloaded with key_load.
  - No start-key register is implemented (saves 128 flops).

Decomposition:
- Shared package aes_pkg: state enum (IDLE/EXPAND/READY), RCON table as a 10x8 constant, NR_128 = 10, sbox function (shared with the round datapath).
- One sub-module, aes_key_step_128: purely combinational fwd/inv single-round key step.
  - Inputs: key, rcon, dir.
  - Shares one 4-S-box SubWord between both directions.

Test Plan:
1. Encrypt walk: key_load, enc_dec=1, key 2b7e151628aed2a6abf7158809cf4f3c -> next cycle k0 = same key, idx 0. After 1 step: a0fafe1788542cb123a339392a6c7605, idx 1. After 10 steps: d014f9a8c9ee2589e13f0cc8b6630ca6, last_key=1.
2. Decrypt walk: same key, enc_dec=0 -> busy for 10 cycles; key_ready at load+11 with d014f9a8c9ee2589e13f0cc8b6630ca6, idx 10. Ten steps reach k0 = 2b7e1516..4f3c, idx 0, last_key=1.
3. Abort: key_load of key 000102030405060708090a0b0c0d0e0f (dec) at EXPAND cycle 5 -> counter restarts. key_ready at the new load+11 with k10 = 13111d7fe3944a17f307a78b4d2b30c5.
4. Collisions: step asserted while busy, and key_load+step in the same cycle -> the steps are ignored and key_load wins. round_idx=0 (enc) the cycle after.
5. Reset mid-READY at idx 4 -> next cycle all outputs 0, state IDLE. A subsequent step is ignored.
6. End of sequence: step at last_key -> with AES_KSCHED_REWIND_EN, k0/idx 0 (enc) next cycle with key_ready=1; without it, key_ready=0.
